// File: rtl/bsg_priority_encode_iter.sv
// Iterative priority encoder: accepts a request vector and emits one set-bit index per yumi.
// Optional BSG_PRIORITY_ENCODE_ITER_COUNT_EN adds count_o (indices still pending).
module bsg_priority_encode_iter #(
  parameter int width_p = 16,
  parameter int lo_to_hi_p = 1,
  localparam int lg_width_lp = $clog2(width_p)
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   v_i,
  input  logic [width_p-1:0]     vec_i,
  output logic                   ready_o,
  output logic                   v_o,
  output logic [lg_width_lp-1:0] addr_o,
  output logic                   last_o,
  input  logic                   yumi_i
`ifdef BSG_PRIORITY_ENCODE_ITER_COUNT_EN
  ,
  output logic [$clog2(width_p+1)-1:0] count_o
`endif
);

  localparam logic IDLE = 1'b0;
  localparam logic BUSY = 1'b1;

  logic                   state_r;
  logic                   ready_r;
  logic [width_p-1:0]     pending_r;
  logic [lg_width_lp-1:0] addr_s;
  logic [width_p-1:0]     sel_s;
  logic [width_p-1:0]     rem_s;
  logic                   accept_s;

  // Priority encode of pending_r; the last hit in scan order has highest priority.
  always_comb begin
    addr_s = {lg_width_lp{1'b0}};
    for (int i = 0; i < width_p; i++) begin
      if (lo_to_hi_p != 0) begin
        if (pending_r[width_p-1-i]) addr_s = lg_width_lp'(width_p-1-i);
        else addr_s = addr_s;
      end else begin
        if (pending_r[i]) addr_s = lg_width_lp'(i);
        else addr_s = addr_s;
      end
    end
  end

  assign sel_s    = {{(width_p-1){1'b0}}, 1'b1} << addr_s;
  assign rem_s    = pending_r & ~sel_s;
  assign accept_s = v_i & ready_r;

  // Handshake FSM and pending vector; an empty vector is consumed without leaving IDLE.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r   <= IDLE;
      ready_r   <= 1'b1;
      pending_r <= {width_p{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s && (vec_i != {width_p{1'b0}})) begin
            pending_r <= vec_i;
            state_r   <= BUSY;
            ready_r   <= 1'b0;
          end
        end
        BUSY: begin
          if (yumi_i) begin
            pending_r <= rem_s;
            if (rem_s == {width_p{1'b0}}) begin
              state_r <= IDLE;
              ready_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r   <= IDLE;
          ready_r   <= 1'b1;
          pending_r <= {width_p{1'b0}};
        end
      endcase
    end
  end

  assign ready_o = ready_r;
  assign v_o     = state_r;
  assign addr_o  = addr_s;
  assign last_o  = state_r & (rem_s == {width_p{1'b0}});

`ifdef BSG_PRIORITY_ENCODE_ITER_COUNT_EN
  localparam int count_w_lp = $clog2(width_p+1);

  function automatic logic [count_w_lp-1:0] popcount(input logic [width_p-1:0] v);
    logic [count_w_lp-1:0] c;
    c = {count_w_lp{1'b0}};
    for (int i = 0; i < width_p; i++) begin
      c = c + count_w_lp'(v[i]);
    end
    return c;
  endfunction

  logic [count_w_lp-1:0] count_r;

  // Remaining-index counter: loaded on accept, decremented per yumi.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      count_r <= {count_w_lp{1'b0}};
    end else if (state_r == IDLE) begin
      if (accept_s) count_r <= popcount(vec_i);
      else count_r <= {count_w_lp{1'b0}};
    end else if (yumi_i) begin
      count_r <= count_r - count_w_lp'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count_o = count_r;
`endif

  bsg_priority_encode_iter_chk chk (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_o       (state_r),
    .yumi_i    (yumi_i)
  );

endmodule

// Simulation-only protocol check: yumi must not arrive without a valid index.
module bsg_priority_encode_iter_chk (
  input logic clk_i,
  input logic reset_n_i,
  input logic v_o,
  input logic yumi_i
);
  always @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(yumi_i && !v_o));
    end
  end
endmodule

// File: tb/tb_bsg_priority_encode_iter.sv
// Directed bench for bsg_priority_encode_iter: a lo-to-hi and a hi-to-lo instance share stimulus.
module tb_bsg_priority_encode_iter;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        v_i = 1'b0;
  logic [15:0] vec_i = 16'h0000;
  logic        yumi_i = 1'b0;
  logic        ready_l, v_l, last_l, ready_h, v_h, last_h;
  logic [3:0]  addr_l, addr_h;
`ifdef BSG_PRIORITY_ENCODE_ITER_COUNT_EN
  logic [4:0]  count_l, count_h;
`endif
  int checks = 0;
  int errors = 0;
  logic [3:0] exp_lo [4];
  logic [3:0] exp_hi [4];

  always #5 clk = ~clk;

  bsg_priority_encode_iter #(.width_p(16), .lo_to_hi_p(1)) dut_l (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .vec_i(vec_i), .ready_o(ready_l),
    .v_o(v_l), .addr_o(addr_l), .last_o(last_l), .yumi_i(yumi_i)
`ifdef BSG_PRIORITY_ENCODE_ITER_COUNT_EN
    , .count_o(count_l)
`endif
  );

  bsg_priority_encode_iter #(.width_p(16), .lo_to_hi_p(0)) dut_h (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .vec_i(vec_i), .ready_o(ready_h),
    .v_o(v_h), .addr_o(addr_h), .last_o(last_h), .yumi_i(yumi_i)
`ifdef BSG_PRIORITY_ENCODE_ITER_COUNT_EN
    , .count_o(count_h)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, 32'(ready_l), 32'd1);
    chk({tag, "_v"}, 32'(v_l), 32'd0);
    chk({tag, "_addr"}, 32'(addr_l), 32'd0);
    chk({tag, "_last"}, 32'(last_l), 32'd0);
    chk({tag, "_ready_h"}, 32'(ready_h), 32'd1);
    chk({tag, "_v_h"}, 32'(v_h), 32'd0);
`ifdef BSG_PRIORITY_ENCODE_ITER_COUNT_EN
    chk({tag, "_count"}, 32'(count_l), 32'd0);
`endif
  endtask

  initial begin
    exp_lo[0] = 4'd0;  exp_lo[1] = 4'd5;  exp_lo[2] = 4'd10; exp_lo[3] = 4'd15;
    exp_hi[0] = 4'd15; exp_hi[1] = 4'd10; exp_hi[2] = 4'd5;  exp_hi[3] = 4'd0;
    tick();
    tick();
    reset_n = 1'b1;
    chk_idle("reset");

    // 0x8421 with yumi held high
    v_i = 1'b1; vec_i = 16'h8421;
    tick();
    v_i = 1'b0; yumi_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("p8421_v", 32'(v_l), 32'd1);
      chk("p8421_ready", 32'(ready_l), 32'd0);
      chk("p8421_addr_lo", 32'(addr_l), 32'(exp_lo[k]));
      chk("p8421_addr_hi", 32'(addr_h), 32'(exp_hi[k]));
      chk("p8421_last_lo", 32'(last_l), (k == 3) ? 32'd1 : 32'd0);
      chk("p8421_last_hi", 32'(last_h), (k == 3) ? 32'd1 : 32'd0);
      tick();
    end
    yumi_i = 1'b0;
    chk_idle("p8421_done");

    // empty vector, then single bit
    v_i = 1'b1; vec_i = 16'h0000;
    tick();
    v_i = 1'b0;
    chk_idle("empty");
    v_i = 1'b1; vec_i = 16'h0002;
    tick();
    v_i = 1'b0;
    chk("single_v", 32'(v_l), 32'd1);
    chk("single_addr", 32'(addr_l), 32'd1);
    chk("single_last", 32'(last_l), 32'd1);
    chk("single_addr_h", 32'(addr_h), 32'd1);
    chk("single_last_h", 32'(last_h), 32'd1);
    yumi_i = 1'b1;
    tick();
    yumi_i = 1'b0;
    chk_idle("single_done");

    // 0x0090 with backpressure and a v_i pulse while busy
    v_i = 1'b1; vec_i = 16'h0090;
    tick();
    v_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("bp_addr", 32'(addr_l), 32'd4);
      chk("bp_last", 32'(last_l), 32'd0);
      chk("bp_addr_h", 32'(addr_h), 32'd7);
      chk("bp_ready", 32'(ready_l), 32'd0);
      if (k == 0) begin
        v_i = 1'b1; vec_i = 16'hFFFF;
      end else begin
        v_i = 1'b0;
      end
      tick();
    end
    v_i = 1'b0;
    yumi_i = 1'b1;
    tick();
    chk("bp_addr2", 32'(addr_l), 32'd7);
    chk("bp_last2", 32'(last_l), 32'd1);
    chk("bp_addr2_h", 32'(addr_h), 32'd4);
    chk("bp_last2_h", 32'(last_h), 32'd1);
    tick();
    yumi_i = 1'b0;
    chk_idle("bp_done");

    // reset while busy, then a full 0xFFFF drain
    v_i = 1'b1; vec_i = 16'hFFFF;
    tick();
    v_i = 1'b0; yumi_i = 1'b1;
    chk("rst_addr0", 32'(addr_l), 32'd0);
    tick();
    chk("rst_addr1", 32'(addr_l), 32'd1);
    tick();
    yumi_i = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk_idle("midreset");
    v_i = 1'b1; vec_i = 16'hFFFF;
    tick();
    v_i = 1'b0; yumi_i = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk("full_v", 32'(v_l), 32'd1);
      chk("full_addr", 32'(addr_l), 32'(k));
      chk("full_addr_h", 32'(addr_h), 32'(15 - k));
      chk("full_last", 32'(last_l), (k == 15) ? 32'd1 : 32'd0);
`ifdef BSG_PRIORITY_ENCODE_ITER_COUNT_EN
      chk("full_count", 32'(count_l), 32'(16 - k));
      chk("full_count_h", 32'(count_h), 32'(16 - k));
`endif
      tick();
    end
    yumi_i = 1'b0;
    chk_idle("full_done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
